// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: per-cycle PC/IF-ID/ID-EX sequencing for load-use, redirects, mult/div occupancy and memory stalls.
module hazard_stall_ctrl #(
    parameter int MD_LAT = 4,
    parameter int SCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ifid_rs,
    input  logic [4:0]        ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic              idex_memread,
    input  logic [4:0]        idex_rt,
    input  logic              jump_id,
    input  logic              branch_taken_ex,
    input  logic              md_start_ex,
    input  logic              ext_stall,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic [5:0]        idex_muxcond,
    output logic              idex_bubble,
    output logic              md_busy,
    output logic [SCNT_W-1:0] stall_cycles,
    output logic [7:0]        flush_count
);
    localparam int CW = $clog2(MD_LAT);
    typedef enum logic [1:0] {RUN = 2'd0, MD_WAIT = 2'd1} state_t;
    state_t state;
    logic [CW-1:0] md_cnt;
    logic lu, run, freeze;
    assign lu = idex_memread && idex_rt != 5'd0 &&
                (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
    assign run = state == RUN;
    assign freeze = ext_stall || (state == MD_WAIT && md_cnt != '0);
    assign md_busy = !rst && state == MD_WAIT;
    always_comb begin
        pc_write = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_muxcond = 6'd1;
        idex_bubble = 1'b0;
        if (rst) begin
            pc_write = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_muxcond = 6'd0;
            idex_bubble = 1'b1;
        end else if (freeze) begin
            pc_write = 1'b0;
            ifid_write = 1'b0;
            idex_muxcond = 6'd0;
        end else if (run && branch_taken_ex) begin
            ifid_flush = 1'b1;
            idex_bubble = 1'b1;
        end else if (!(run && md_start_ex)) begin
            // lu and jump also apply on the release cycle of a mult/div wait
            if (lu) begin
                pc_write = 1'b0;
                ifid_write = 1'b0;
                idex_bubble = 1'b1;
            end else if (jump_id) begin
                ifid_flush = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            md_cnt <= '0;
            stall_cycles <= '0;
            flush_count <= '0;
        end else begin
            if (!ext_stall) begin
                if (run && md_start_ex && !branch_taken_ex) begin
                    state <= MD_WAIT;
                    md_cnt <= CW'(MD_LAT - 2);
                end else if (state == MD_WAIT) begin
                    state <= md_cnt == '0 ? RUN : MD_WAIT;
                    md_cnt <= md_cnt == '0 ? md_cnt : md_cnt - 1'b1;
                end
            end
            if (!pc_write && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
            if (ifid_flush && flush_count != 8'hff) flush_count <= flush_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and random stimulus scored against a cycle-level model of the sequencing rules.
module tb_hazard_stall_ctrl;
    localparam int MD_LAT = 4;
    logic clk = 0, rst = 1;
    logic [4:0] ifid_rs = 0, ifid_rt = 0, idex_rt = 0;
    logic ifid_uses_rt = 0, idex_memread = 0, jump_id = 0, branch_taken_ex = 0, md_start_ex = 0, ext_stall = 0;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, md_busy;
    logic pc_write4, ifid_write4, ifid_flush4, idex_bubble4, md_busy4;
    logic [5:0] idex_muxcond, idex_muxcond4;
    logic [15:0] stall_cycles;
    logic [3:0] stall_cycles4;
    logic [7:0] flush_count, flush_count4;
    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MD_LAT(MD_LAT), .SCNT_W(16)) dut (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .jump_id(jump_id),
        .branch_taken_ex(branch_taken_ex), .md_start_ex(md_start_ex), .ext_stall(ext_stall),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_muxcond(idex_muxcond), .idex_bubble(idex_bubble), .md_busy(md_busy),
        .stall_cycles(stall_cycles), .flush_count(flush_count));

    hazard_stall_ctrl #(.MD_LAT(MD_LAT), .SCNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .jump_id(jump_id),
        .branch_taken_ex(branch_taken_ex), .md_start_ex(md_start_ex), .ext_stall(ext_stall),
        .pc_write(pc_write4), .ifid_write(ifid_write4), .ifid_flush(ifid_flush4),
        .idex_muxcond(idex_muxcond4), .idex_bubble(idex_bubble4), .md_busy(md_busy4),
        .stall_cycles(stall_cycles4), .flush_count(flush_count4));

    typedef struct {
        bit pc, ifw, fl, bub, busy;
        int mux, sc, fc;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;
    int wait_left = 0, stalls = 0, flushes = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // wait_left counts the mult/div cycles still owned by EX, release cycle included
    task automatic step(input bit r, input bit [4:0] rs, input bit [4:0] rt, input bit ur, input bit mr,
                        input bit [4:0] xrt, input bit j, input bit b, input bit m, input bit e);
        exp_t x;
        bit lu;
        @(posedge clk);
        #1;
        rst = r; ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = ur; idex_memread = mr;
        idex_rt = xrt; jump_id = j; branch_taken_ex = b; md_start_ex = m; ext_stall = e;
        lu = mr && xrt != 0 && (xrt == rs || (ur && xrt == rt));
        x = '{pc: 1, ifw: 1, fl: 0, bub: 0, busy: 0, mux: 1, sc: stalls, fc: flushes};
        if (r) begin
            x.pc = 0; x.ifw = 0; x.fl = 1; x.mux = 0; x.bub = 1;
        end else begin
            x.busy = wait_left > 0;
            if (e || wait_left > 1) begin
                x.pc = 0; x.ifw = 0; x.mux = 0;
            end else if (wait_left == 0 && b) begin
                x.fl = 1; x.bub = 1;
            end else if (wait_left == 0 && m) begin
            end else if (lu) begin
                x.pc = 0; x.ifw = 0; x.bub = 1;
            end else if (j) x.fl = 1;
        end
        q.push_back(x);
        if (r) begin
            wait_left = 0; stalls = 0; flushes = 0;
        end else begin
            if (!e) begin
                if (wait_left > 0) wait_left--;
                else if (m && !b) wait_left = MD_LAT - 1;
            end
            if (!x.pc) stalls++;
            if (x.fl && flushes < 255) flushes++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("pc_write", int'(pc_write), int'(x.pc));
                chk("ifid_write", int'(ifid_write), int'(x.ifw));
                chk("ifid_flush", int'(ifid_flush), int'(x.fl));
                chk("idex_muxcond", int'(idex_muxcond), x.mux);
                chk("idex_bubble", int'(idex_bubble), int'(x.bub));
                chk("md_busy", int'(md_busy), int'(x.busy));
                chk("stall_cycles", int'(stall_cycles), x.sc > 65535 ? 65535 : x.sc);
                chk("stall_cycles_w4", int'(stall_cycles4), x.sc > 15 ? 15 : x.sc);
                chk("flush_count", int'(flush_count), x.fc);
                chk("pc_write_w4", int'(pc_write4), int'(x.pc));
            end
        end
    end

    initial begin : stim
        step(1, 5'($urandom), 5'($urandom), 1'($urandom), 1, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        step(1, 5'($urandom), 5'($urandom), 1'($urandom), 1, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        idle(2);
        step(0, 5, 0, 0, 1, 5, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 3, 7, 1, 1, 7, 0, 0, 0, 0);
        step(0, 3, 7, 0, 1, 7, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(4);
        step(0, 5, 0, 0, 1, 5, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 9, 0, 0, 1, 9, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 4, 0, 0, 1, 4, 1, 0, 0, 0);
        step(0, 4, 0, 0, 1, 4, 1, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
